alu_core: RTL and testbench
===========================

// Module: alu_core
// PURPOSE
//  Integer ALU and branch comparator for the multi-cycle RV32I core.
//  The core drives a 4-bit op, which is {funct7[5] qualifier, funct3}, plus two operands.
//  The block returns a combinational result (register writeback, JALR target) and a compare flag (branch taken).
//  An optional pipeline register provides one-cycle-late copies of both outputs.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a power of two >= 8; SHW = $clog2(WIDTH)
// PORTS
//  clk     in   1      single clock; all flops rise-edge
//  rts     in   1      reset: synchronous, active-high
//  op      in   4      {ex, funct3}; ex = instr[30] (core forces 0 where not applicable)
//  a       in   WIDTH  operand A (rs1)
//  b       in   WIDTH  operand B (rs2 or sign-extended imm)
//  result  out  WIDTH  combinational ALU result
//  cmp     out  1      combinational branch condition, decoded from funct3 = op[2:0] only
//  res_q   out  WIDTH  registered result (see CONFIGURATION)
//  cmp_q   out  1      registered cmp (see CONFIGURATION)
// BEHAVIOUR
//  result, decoded by op[2:0]; ex (op[3]) matters only for 000 and 101:
//   000: ex=0 a+b, ex=1 a-b; both modulo 2^WIDTH, no carry/overflow out
//   001: SLL  a << b[SHW-1:0]; bit b[SHW] and all higher bits of b are ignored
//   010: SLT  {0..,1} if $signed(a)<$signed(b), else 0
//   011: SLTU {0..,1} if a<b unsigned, else 0
//   100: XOR a^b      110: OR a|b      111: AND a&b
//   101: ex=0 SRL logical a >> b[SHW-1:0]; ex=1 SRA arithmetic (sign-fill)
//   Shift by 0 returns a unchanged. Shift by WIDTH-1 is legal.
//  cmp, decoded by op[2:0]; ex is ignored because branch instr[30] is an immediate bit:
//   000 a==b   001 a!=b   100 signed a<b   101 signed a>=b
//   110 unsigned a<b   111 unsigned a>=b   010/011: 0
//  result and cmp are purely combinational, zero latency, and unaffected by rts.
//  Boundaries:
//   0x80000000-1 wraps to 0x7FFFFFFF
//   SLT 0x80000000 vs 0x00000000 = 1; SLTU of the same pair = 0
//   SRA 0x80000000 by 31 = 0xFFFFFFFF
//   Equal operands: BGE/BGEU true, BLT/BLTU false
//  No X-propagation paths; every op value yields a defined output (full case).
// CONFIGURATION
//  Macro ALU_PIPE_EN:
//   Defined: res_q/cmp_q are flops updated every clk from result/cmp.
//    rts=1 at an edge clears res_q=0 and cmp_q=0; this includes reset mid-stream,
//    where the next un-reset edge captures current inputs. Latency is 1 cycle.
//   Undefined: res_q=result and cmp_q=cmp combinationally, with no flops;
//    clk/rts are unused but the ports remain (lint waiver).
// STRUCTURE
//  Package alu_pkg:
//   localparams for op codes: ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL=3'b001, ALU_SLT=3'b010,
//    ALU_SLTU=3'b011, ALU_XOR=3'b100, ALU_SRL=4'b0101, ALU_SRA=4'b1101, ALU_OR=3'b110, ALU_AND=3'b111
//   branch funct3 codes: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111
//  Sub-module alu_cmp(a,b,funct3 -> cmp) holds the comparator.
//   It shares no logic with the SLT path except the signed/unsigned less-than helpers defined in alu_pkg.
// TESTING
//  op=0000 a=0xFFFFFFFF b=1 -> result=0; op=1000 a=0 b=1 -> result=0xFFFFFFFF
//  op=1101 a=0x80000000 b=31 -> 0xFFFFFFFF; op=0101 same -> 0x00000001;
//   op=0001 a=1 b=0x20 -> 1 (amount masked)
//  op=0010 a=0x80000000 b=0 -> 1; op=0011 same -> 0; op=0100 a=0xF0F0 b=0xFF00 -> 0x0FF0
//  cmp: funct3=101 with op[3]=1 a=5 b=5 -> 1; 100 a=-1 b=0 -> 1; 110 a=-1 b=0 -> 0; 010 -> 0
//  ALU_PIPE_EN: drive op=0000 a=2 b=3 -> res_q=5 one edge later;
//   assert rts at the next edge -> res_q=0 and cmp_q=0, while result still reads 5
//  Random 10k vectors vs golden model for all 16 op values; undefined: res_q==result every sample

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op/branch encodings and the less-than helpers for the RV32I ALU and its branch comparator.
package alu_pkg;

    // Widest operand the helpers cover; callers extend their operands to this width.
    localparam int ALU_MAX_W = 64;

    // ALU op codes: {ex, funct3} where ex matters, funct3 alone otherwise
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    // Branch funct3 codes
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    function automatic logic lt_u(input logic [ALU_MAX_W-1:0] x,
                                  input logic [ALU_MAX_W-1:0] y);
        return x < y;
    endfunction

    // Operands must arrive sign-extended from their native width.
    function automatic logic lt_s(input logic [ALU_MAX_W-1:0] x,
                                  input logic [ALU_MAX_W-1:0] y);
        return $signed(x) < $signed(y);
    endfunction

endpackage

// File: rtl/alu_cmp.sv
// Branch comparator: decodes funct3 into the branch-taken condition.
module alu_cmp
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       funct3,
    output logic             cmp
);

    logic eq;
    logic lt_sg;
    logic lt_us;

    assign eq    = (a == b);
    assign lt_sg = lt_s(ALU_MAX_W'($signed(a)), ALU_MAX_W'($signed(b)));
    assign lt_us = lt_u(ALU_MAX_W'(a), ALU_MAX_W'(b));

    always_comb begin
        cmp = 1'b0;
        case (funct3)
            BEQ:     cmp = eq;
            BNE:     cmp = ~eq;
            BLT:     cmp = lt_sg;
            BGE:     cmp = ~lt_sg;
            BLTU:    cmp = lt_us;
            BGEU:    cmp = ~lt_us;
            default: cmp = 1'b0;   // 010/011 are not branches
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// RV32I integer ALU plus branch comparator, with optional registered copies of both outputs.
// Macro ALU_PIPE_EN: defined -> res_q/cmp_q are flops; undefined -> they alias result/cmp.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rts,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cmp,
    output logic [WIDTH-1:0] res_q,
    output logic             cmp_q
);

    localparam int SHW = $clog2(WIDTH);

    if (WIDTH < 8 || WIDTH > ALU_MAX_W || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("alu_core: WIDTH must be a power of two in [8, %0d]", ALU_MAX_W);
    end

    logic           ex;
    logic [2:0]     funct3;
    logic [SHW-1:0] shamt;
    logic           slt_bit;
    logic           sltu_bit;

    assign ex       = op[3];
    assign funct3   = op[2:0];
    assign shamt    = b[SHW-1:0];   // upper bits of b never affect a shift
    assign slt_bit  = lt_s(ALU_MAX_W'($signed(a)), ALU_MAX_W'($signed(b)));
    assign sltu_bit = lt_u(ALU_MAX_W'(a), ALU_MAX_W'(b));

    always_comb begin
        result = '0;
        case (funct3)
            ALU_ADD[2:0]: result = ex ? (a - b) : (a + b);
            ALU_SLL:      result = a << shamt;
            ALU_SLT:      result = WIDTH'(slt_bit);
            ALU_SLTU:     result = WIDTH'(sltu_bit);
            ALU_XOR:      result = a ^ b;
            ALU_SRL[2:0]: result = ex ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);
            ALU_OR:       result = a | b;
            ALU_AND:      result = a & b;
            default:      result = '0;
        endcase
    end

    // Branch instr[30] is an immediate bit, so the comparator never sees ex.
    alu_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a      (a),
        .b      (b),
        .funct3 (funct3),
        .cmp    (cmp)
    );

`ifdef ALU_PIPE_EN
    always_ff @(posedge clk) begin
        if (rts) begin
            res_q <= '0;
            cmp_q <= 1'b0;
        end else begin
            res_q <= result;
            cmp_q <= cmp;
        end
    end
`else
    assign res_q = result;
    assign cmp_q = cmp;

    // Clock and reset stay on the port list so both builds share one interface.
    logic unused_clk_rts;
    assign unused_clk_rts = clk ^ rts;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed table, pipeline/reset sequences, random vs reference model.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rts;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] result, res_q;
    logic        cmp, cmp_q;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_core #(.WIDTH(32)) dut (
        .clk    (clk),
        .rts    (rts),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .cmp    (cmp),
        .res_q  (res_q),
        .cmp_q  (cmp_q)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values, shifts as powers of two.
    function automatic void model(input logic [3:0] m_op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic c);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'b0, x});
        longint uy = longint'({32'b0, y});
        int     sh = int'(y % 32);
        longint p2 = 1;
        longint q;
        for (int i = 0; i < sh; i++) p2 = p2 * 2;
        case (m_op[2:0])
            3'd0: r = m_op[3] ? 32'(ux - uy) : 32'(ux + uy);
            3'd1: r = 32'(ux * p2);
            3'd2: r = (sx < sy) ? 32'd1 : 32'd0;
            3'd3: r = (ux < uy) ? 32'd1 : 32'd0;
            3'd4: r = x ^ y;
            3'd5: begin
                if (!m_op[3]) q = ux / p2;
                else if (sx >= 0) q = sx / p2;
                else q = -((-sx + p2 - 1) / p2);
                r = 32'(q);
            end
            3'd6: r = x | y;
            default: r = x & y;
        endcase
        case (m_op[2:0])
            3'd0: c = (sx == sy);
            3'd1: c = (sx != sy);
            3'd4: c = (sx < sy);
            3'd5: c = (sx >= sy);
            3'd6: c = (ux < uy);
            3'd7: c = (ux >= uy);
            default: c = 1'b0;
        endcase
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cmp;
        bit          chk_res;
        bit          chk_cmp;
    } vec_t;

    function automatic logic [31:0] pick();
        logic [31:0] edges [8] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                   32'h7FFF_FFFF, 32'h1F, 32'h20, 32'h5};
        if ($urandom_range(3) == 0) return edges[$urandom_range(7)];
        return $urandom;
    endfunction

    initial begin
        vec_t        tbl [18];
        logic [31:0] er;
        logic        ec;

        tbl[0]  = '{4'b0000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0};
        tbl[1]  = '{4'b1000, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1, 0};
        tbl[2]  = '{4'b1000, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1, 0};
        tbl[3]  = '{4'b1101, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 1, 0};
        tbl[4]  = '{4'b0101, 32'h8000_0000, 32'd31,        32'h1,         1'b0, 1, 0};
        tbl[5]  = '{4'b0001, 32'h1,         32'h20,        32'h1,         1'b0, 1, 0};
        tbl[6]  = '{4'b0010, 32'h8000_0000, 32'h0,         32'h1,         1'b0, 1, 0};
        tbl[7]  = '{4'b0011, 32'h8000_0000, 32'h0,         32'h0,         1'b0, 1, 0};
        tbl[8]  = '{4'b0100, 32'hF0F0,      32'hFF00,      32'h0FF0,      1'b0, 1, 0};
        tbl[9]  = '{4'b0001, 32'h1234_5678, 32'h0,         32'h1234_5678, 1'b0, 1, 0};
        tbl[10] = '{4'b1101, 32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321, 1'b0, 1, 0};
        tbl[11] = '{4'b1101, 32'd5,         32'd5,         32'h0,         1'b1, 0, 1};
        tbl[12] = '{4'b0100, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 0, 1};
        tbl[13] = '{4'b0110, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0, 0, 1};
        tbl[14] = '{4'b0010, 32'd1,         32'd2,         32'h0,         1'b0, 0, 1};
        tbl[15] = '{4'b0111, 32'd5,         32'd5,         32'h0,         1'b1, 0, 1};
        tbl[16] = '{4'b0100, 32'd5,         32'd5,         32'h0,         1'b0, 0, 1};
        tbl[17] = '{4'b0110, 32'd5,         32'd5,         32'h0,         1'b0, 0, 1};

        rts = 1'b1; op = 4'b0000; a = 32'd7; b = 32'd9;
        repeat (2) @(posedge clk);
        #1;
`ifdef ALU_PIPE_EN
        check("reset res_q", res_q, 32'h0);
        check("reset cmp_q", {31'b0, cmp_q}, 32'h0);
`else
        check("reset res_q alias", res_q, 32'd16);
`endif
        check("result during reset", result, 32'd16);
        @(negedge clk);
        rts = 1'b0;

        foreach (tbl[i]) begin
            op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
            #1;
            if (tbl[i].chk_res) check($sformatf("tbl[%0d] result", i), result, tbl[i].res);
            if (tbl[i].chk_cmp) check($sformatf("tbl[%0d] cmp", i), {31'b0, cmp}, {31'b0, tbl[i].cmp});
        end

`ifdef ALU_PIPE_EN
        // capture, reset clears both flops while result stays live, release captures again
        @(negedge clk); op = 4'b0000; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        check("pipe res_q 3+3", res_q, 32'd6);
        check("pipe cmp_q 3==3", {31'b0, cmp_q}, 32'h1);
        @(negedge clk); a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        check("pipe res_q 2+3", res_q, 32'd5);
        check("pipe cmp_q 2==3", {31'b0, cmp_q}, 32'h0);
        @(negedge clk); a = 32'd4; b = 32'd4; rts = 1'b1;
        @(posedge clk); #1;
        check("mid reset res_q", res_q, 32'h0);
        check("mid reset cmp_q", {31'b0, cmp_q}, 32'h0);
        check("mid reset result", result, 32'd8);
        @(negedge clk); rts = 1'b0;
        @(posedge clk); #1;
        check("post reset res_q", res_q, 32'd8);
        check("post reset cmp_q", {31'b0, cmp_q}, 32'h1);
`endif

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(15)); a = pick(); b = pick();
            model(op, a, b, er, ec);
            #1;
            check($sformatf("rnd op=%b a=%h b=%h result", op, a, b), result, er);
            check($sformatf("rnd op=%b a=%h b=%h cmp", op, a, b), {31'b0, cmp}, {31'b0, ec});
`ifdef ALU_PIPE_EN
            @(posedge clk); #1;
            check("rnd res_q", res_q, er);
            check("rnd cmp_q", {31'b0, cmp_q}, {31'b0, ec});
`else
            check("rnd res_q alias", res_q, er);
            check("rnd cmp_q alias", {31'b0, cmp_q}, {31'b0, ec});
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
